// File: rtl/clock_divider_controller.sv
// Programmable 50%-duty clock generator with glitch-free divisor switching and stop.
// Define CYCLE_COUNT_EN to add the 16-bit cycle_count output (ticks since last start).
module clock_divider_controller #(
  parameter int DIV_WIDTH   = 24,
  parameter int DEFAULT_DIV = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 cfg_req,
  input  logic [DIV_WIDTH-1:0] cfg_div,
  output logic                 cfg_ack,
  output logic                 cfg_err,
  output logic                 busy,
  output logic                 clk_Signal,
  output logic                 tick
`ifdef CYCLE_COUNT_EN
  ,
  output logic [15:0]          cycle_count
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    SWITCH
  } state_t;

  localparam logic [DIV_WIDTH-1:0] ONE = DIV_WIDTH'(1);

  state_t               state, state_n;
  logic [DIV_WIDTH-1:0] counter, counter_n;
  logic [DIV_WIDTH-1:0] div_reg, div_n;
  logic [DIV_WIDTH-1:0] pending_div, pending_n;
  logic                 cfg_req_q;
  logic                 stop_pend, stop_pend_n;
  logic                 clk_n, tick_n, ack_n, err_n;

  logic cfg_rise, cfg_valid, cfg_bad, at_wrap, fall, go_idle;

  // A request is only considered while nothing else is pending.
  assign busy      = (state == SWITCH) | stop_pend;
  assign cfg_rise  = cfg_req & ~cfg_req_q;
  assign cfg_valid = cfg_rise & ~busy & (cfg_div != '0);
  assign cfg_bad   = cfg_rise & ~busy & (cfg_div == '0);
  assign at_wrap   = (counter == div_reg - ONE);
  assign fall      = at_wrap & clk_Signal;
  assign go_idle   = (stop & ~clk_Signal) | (fall & (stop | stop_pend));

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_n     = state;
    counter_n   = counter;
    div_n       = div_reg;
    pending_n   = pending_div;
    stop_pend_n = stop_pend;
    clk_n       = clk_Signal;
    tick_n      = 1'b0;
    ack_n       = 1'b0;
    err_n       = cfg_bad;

    unique case (state)
      IDLE: begin
        counter_n   = '0;
        clk_n       = 1'b0;
        stop_pend_n = 1'b0;
        if (cfg_valid) begin
          div_n = cfg_div;
          ack_n = 1'b1;
        end
        if (start && !stop) state_n = RUN;
      end

      RUN, SWITCH: begin
        counter_n = at_wrap ? '0 : counter + ONE;
        clk_n     = clk_Signal ^ at_wrap;
        tick_n    = at_wrap & ~clk_Signal;

        if (state == RUN && cfg_valid) begin
          pending_n = cfg_div;
          state_n   = SWITCH;
        end

        if (go_idle) begin
          // Stopping applies whatever divisor change is outstanding.
          state_n     = IDLE;
          counter_n   = '0;
          clk_n       = 1'b0;
          tick_n      = 1'b0;
          stop_pend_n = 1'b0;
          if (state == SWITCH) begin
            div_n = pending_div;
            ack_n = 1'b1;
          end else if (cfg_valid) begin
            div_n = cfg_div;
            ack_n = 1'b1;
          end
        end else if (fall && state == SWITCH) begin
          div_n   = pending_div;
          ack_n   = 1'b1;
          state_n = RUN;
        end else if (stop) begin
          stop_pend_n = 1'b1;
        end
      end

      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!reset) begin
      state       <= IDLE;
      counter     <= '0;
      div_reg     <= DIV_WIDTH'(DEFAULT_DIV);
      pending_div <= '0;
      cfg_req_q   <= 1'b0;
      stop_pend   <= 1'b0;
      clk_Signal  <= 1'b0;
      tick        <= 1'b0;
      cfg_ack     <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      state       <= state_n;
      counter     <= counter_n;
      div_reg     <= div_n;
      pending_div <= pending_n;
      cfg_req_q   <= cfg_req;
      stop_pend   <= stop_pend_n;
      clk_Signal  <= clk_n;
      tick        <= tick_n;
      cfg_ack     <= ack_n;
      cfg_err     <= err_n;
    end
  end

`ifdef CYCLE_COUNT_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      cycle_count <= '0;
    end else if (state == IDLE && state_n == RUN) begin
      cycle_count <= '0;
    end else if (tick_n) begin
      cycle_count <= cycle_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_clock_divider_controller.sv
// Directed self-checking bench for clock_divider_controller (default parameters).
// Define CYCLE_COUNT_EN to also check the cycle_count output.
module tb_clock_divider_controller;

  localparam int DIV_WIDTH = 24;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 start;
  logic                 stop;
  logic                 cfg_req;
  logic [DIV_WIDTH-1:0] cfg_div;
  logic                 cfg_ack;
  logic                 cfg_err;
  logic                 busy;
  logic                 clk_Signal;
  logic                 tick;
`ifdef CYCLE_COUNT_EN
  logic [15:0]          cycle_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int len, acks, errs, ticks, busys, highs;

  always #5 clk = ~clk;

  clock_divider_controller #(
    .DIV_WIDTH  (DIV_WIDTH),
    .DEFAULT_DIV(5)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .stop       (stop),
    .cfg_req    (cfg_req),
    .cfg_div    (cfg_div),
    .cfg_ack    (cfg_ack),
    .cfg_err    (cfg_err),
    .busy       (busy),
    .clk_Signal (clk_Signal),
    .tick       (tick)
`ifdef CYCLE_COUNT_EN
    ,
    .cycle_count(cycle_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Advance until clk_Signal changes; len counts cycles up to and including the toggle.
  task automatic run_phase(output int p_len, output int p_acks, output int p_errs,
                           output int p_ticks, output int p_busys);
    logic v;
    logic done;
    v = clk_Signal;
    done = 1'b0;
    p_len = 0; p_acks = 0; p_errs = 0; p_ticks = 0; p_busys = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      step();
      p_len++;
      p_acks  += int'(cfg_ack);
      p_errs  += int'(cfg_err);
      p_ticks += int'(tick);
      p_busys += int'(busy);
      if (clk_Signal !== v) done = 1'b1;
    end
    if (!done) p_len = 0;
  endtask

  // Run n cycles, counting clk_Signal high samples and ack pulses.
  task automatic idle_watch(input int n, output int p_highs, output int p_acks);
    p_highs = 0;
    p_acks  = 0;
    for (int i = 0; i < n; i++) begin
      step();
      p_highs += int'(clk_Signal);
      p_acks  += int'(cfg_ack);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; start = 1'b0; stop = 1'b0; cfg_req = 1'b0; cfg_div = '0;
    repeat (3) step();
    check("rst_clk_signal", 32'(clk_Signal), 0);
    check("rst_tick",       32'(tick),       0);
    check("rst_cfg_ack",    32'(cfg_ack),    0);
    check("rst_cfg_err",    32'(cfg_err),    0);
    check("rst_busy",       32'(busy),       0);
`ifdef CYCLE_COUNT_EN
    check("rst_cycle_count", 32'(cycle_count), 0);
`endif
    reset = 1'b1;
    step();

    // start and stop together: stop wins, no clock appears
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    idle_watch(12, highs, acks);
    check("start_stop_idle", 32'(highs), 0);

    // default divisor 5: 5 low, 5 high, tick on each rising edge
    pulse_start();
    run_phase(len, acks, errs, ticks, busys);
    check("first_low_len", 32'(len), 5);
    check("first_low_tick", 32'(ticks), 1);
    check("tick_at_rise", 32'(tick), 1);
`ifdef CYCLE_COUNT_EN
    check("cycle_count_1", 32'(cycle_count), 1);
`endif
    run_phase(len, acks, errs, ticks, busys);
    check("high_len_5", 32'(len), 5);
    check("high_no_tick", 32'(ticks), 0);
    run_phase(len, acks, errs, ticks, busys);
    check("low_len_5", 32'(len), 5);
    check("second_tick", 32'(ticks), 1);
`ifdef CYCLE_COUNT_EN
    check("cycle_count_2", 32'(cycle_count), 2);
`endif

    // cfg_div == 0 during RUN: one error pulse, period unchanged
    cfg_div = '0; cfg_req = 1'b1;
    run_phase(len, acks, errs, ticks, busys);
    check("zero_div_err", 32'(errs), 1);
    check("zero_div_no_ack", 32'(acks), 0);
    check("zero_div_high_len", 32'(len), 5);
    cfg_req = 1'b0;
    run_phase(len, acks, errs, ticks, busys);
    check("zero_div_low_len", 32'(len), 5);

    // switch to 3 requested one cycle into a high phase
    step();
    cfg_div = 3; cfg_req = 1'b1;
    run_phase(len, acks, errs, ticks, busys);
    check("switch_high_rest", 32'(len), 4);
    check("switch_ack", 32'(acks), 1);
    check("switch_busy_cycles", 32'(busys), 3);
    check("switch_busy_drop", 32'(busy), 0);
    cfg_req = 1'b0;
    run_phase(len, acks, errs, ticks, busys);
    check("div3_low_len", 32'(len), 3);
    check("div3_low_no_ack", 32'(acks), 0);
    run_phase(len, acks, errs, ticks, busys);
    check("div3_high_len", 32'(len), 3);

    // second request while switching is ignored
    cfg_div = 5; cfg_req = 1'b1;
    step();
    check("switch2_busy", 32'(busy), 1);
    cfg_req = 1'b0;
    step();
    cfg_div = 7; cfg_req = 1'b1;
    step();
    check("ignored_err", 32'(cfg_err), 0);
    check("ignored_ack", 32'(cfg_ack), 0);
    check("old_div_low_len", 32'(clk_Signal), 1);
    cfg_req = 1'b0;
    run_phase(len, acks, errs, ticks, busys);
    check("old_div_high_len", 32'(len), 3);
    check("first_req_acked", 32'(acks), 1);
    run_phase(len, acks, errs, ticks, busys);
    check("applied_div5_low", 32'(len), 5);
    run_phase(len, acks, errs, ticks, busys);
    check("applied_div5_high", 32'(len), 5);
    check("no_second_ack", 32'(acks), 0);

    // stop during a low phase: IDLE next cycle
    step(); step();
    stop = 1'b1;
    step();
    check("stop_low_clk", 32'(clk_Signal), 0);
    check("stop_low_busy", 32'(busy), 0);
    stop = 1'b0;
    idle_watch(12, highs, acks);
    check("stop_low_idle", 32'(highs), 0);

    // stop two cycles into a high phase finishes the high phase
    pulse_start();
    run_phase(len, acks, errs, ticks, busys);
    check("restart_low_len", 32'(len), 5);
    step(); step();
    stop = 1'b1;
    step();
    check("stop_high_busy", 32'(busy), 1);
    check("stop_high_clk", 32'(clk_Signal), 1);
    stop = 1'b0;
    run_phase(len, acks, errs, ticks, busys);
    check("stop_high_rest", 32'(len), 2);
    check("stop_high_busy_drop", 32'(busy), 0);
    idle_watch(12, highs, acks);
    check("stop_high_idle", 32'(highs), 0);
    pulse_start();
    run_phase(len, acks, errs, ticks, busys);
    check("restart2_low_len", 32'(len), 5);

    // load divisor 1 from IDLE
    stop = 1'b1;
    run_phase(len, acks, errs, ticks, busys);
    check("stop_full_high", 32'(len), 5);
    stop = 1'b0;
    cfg_div = 1; cfg_req = 1'b1;
    step();
    check("idle_load_ack", 32'(cfg_ack), 1);
    check("idle_load_err", 32'(cfg_err), 0);
    cfg_req = 1'b0;
    step();
    check("idle_ack_one_cycle", 32'(cfg_ack), 0);
    pulse_start();
    run_phase(len, acks, errs, ticks, busys);
    check("div1_low_len", 32'(len), 1);
    run_phase(len, acks, errs, ticks, busys);
    check("div1_high_len", 32'(len), 1);

    // maximum divisor accepted; clock stays low for a long time
    stop = 1'b1;
    step();
    stop = 1'b0;
    step();
    cfg_div = '1; cfg_req = 1'b1;
    step();
    check("max_div_ack", 32'(cfg_ack), 1);
    check("max_div_err", 32'(cfg_err), 0);
    cfg_req = 1'b0;
    pulse_start();
    idle_watch(20, highs, acks);
    check("max_div_stays_low", 32'(highs), 0);

    // reset during SWITCH discards the pending request
    cfg_div = 4; cfg_req = 1'b1;
    step();
    check("pre_reset_busy", 32'(busy), 1);
    cfg_req = 1'b0;
    reset = 1'b0;
    step();
    check("mid_rst_clk", 32'(clk_Signal), 0);
    check("mid_rst_tick", 32'(tick), 0);
    check("mid_rst_ack", 32'(cfg_ack), 0);
    check("mid_rst_err", 32'(cfg_err), 0);
    check("mid_rst_busy", 32'(busy), 0);
    step();
    reset = 1'b1;
    idle_watch(20, highs, acks);
    check("post_rst_no_ack", 32'(acks), 0);
    pulse_start();
    run_phase(len, acks, errs, ticks, busys);
    check("post_rst_low_len", 32'(len), 5);
`ifdef CYCLE_COUNT_EN
    check("cycle_count_restart", 32'(cycle_count), 1);
`endif
    run_phase(len, acks, errs, ticks, busys);
    check("post_rst_high_len", 32'(len), 5);
    check("post_rst_no_ack2", 32'(acks), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/clock_divider_controller.md
CLOCK_DIVIDER_CONTROLLER -- requirements
Module: clock_divider_controller

Interface
REQ-001 SHALL have parameter DIV_WIDTH, default 24, width of divisor and counter.
REQ-002 SHALL have parameter DEFAULT_DIV, default 5, half-period length in clk cycles loaded at reset; must be at least 1.
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port start  input  1  request to begin clock generation.
REQ-006 SHALL have port stop  input  1  request to halt clock generation at a glitch-free boundary.
REQ-007 SHALL have port cfg_req  input  1  divisor change request; acted on at its rising edge.
REQ-008 SHALL have port cfg_div  input  DIV_WIDTH  requested half-period in clk cycles.
REQ-009 SHALL have port cfg_ack  output  1  one-cycle pulse when the new divisor takes effect.
REQ-010 SHALL have port cfg_err  output  1  one-cycle pulse when cfg_div==0 is requested.
REQ-011 SHALL have port busy  output  1  high while a divisor change or stop is pending.
REQ-012 SHALL have port clk_Signal  output  1  generated divided clock, registered.
REQ-013 SHALL have port tick  output  1  one-cycle pulse coincident with each 0->1 transition of clk_Signal.

Function
REQ-014 SHALL implement states IDLE, RUN and SWITCH; reset enters IDLE.
REQ-015 IDLE: clk_Signal held 0 and counter held 0; start=1 moves the FSM to RUN next cycle; if start and stop are both 1, stop wins and the FSM stays in IDLE.
REQ-016 RUN/SWITCH: counter increments every cycle; when counter==div_reg-1, counter returns to 0 and clk_Signal toggles, giving a period of 2*div_reg cycles.
REQ-017 First 0->1 transition of clk_Signal SHALL occur div_reg cycles after entering RUN.
REQ-018 A cfg_req rising edge (previous sample 0, current 1) with cfg_div==0 SHALL pulse cfg_err the next cycle, with no ack and no state change.
REQ-019 In IDLE, a valid request SHALL load div_reg immediately and pulse cfg_ack the next cycle.
REQ-020 In RUN, a valid request SHALL latch pending_div, raise busy and enter SWITCH.
REQ-021 In SWITCH, counting SHALL continue with the old div_reg. At the 1->0 toggle of clk_Signal, div_reg<=pending_div, cfg_ack pulses in the same cycle, busy drops and the FSM returns to RUN.
REQ-022 A cfg_req edge while busy=1 SHALL be ignored: no ack, no err.
REQ-023 Stop in RUN or SWITCH with clk_Signal==0 SHALL enter IDLE next cycle; a pending switch is applied and acked in that cycle.
REQ-024 Stop with clk_Signal==1 SHALL set busy, finish the full high phase, then enter IDLE at the 1->0 toggle, applying and acking any pending switch.
REQ-025 clk_Signal SHALL never produce a phase shorter than the div_reg in force at that phase's start, except a low phase truncated by stop.
REQ-026 Counter compare SHALL use full DIV_WIDTH unsigned arithmetic; the maximum cfg_div of 2**DIV_WIDTH-1 SHALL be legal.

Reset
REQ-027 While reset==0 at a clk edge, the block SHALL set state=IDLE, counter=0, div_reg=DEFAULT_DIV, pending_div=0 and the cfg_req edge register=0. clk_Signal, tick, cfg_ack, cfg_err and busy SHALL all be 0.
REQ-028 Reset mid-SWITCH or mid-stop SHALL discard the pending request without ack.

Configuration
REQ-029 When CYCLE_COUNT_EN is defined, the block SHALL add output cycle_count[15:0]. It increments on each tick, wraps 0xFFFF->0x0000, resets to 0 and clears on IDLE->RUN entry.
REQ-030 When CYCLE_COUNT_EN is undefined, the cycle_count port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-031 Reset, then start pulse: clk_Signal is 5 cycles low then 5 high, repeating; tick pulses every 10 cycles, first tick 5 cycles after RUN entry.
REQ-032 In RUN with clk_Signal high and counter=1, cfg_req edge with cfg_div=3: current high phase completes at 5 cycles; cfg_ack pulses at the falling toggle; subsequent phases are 3 cycles; busy is high in between.
REQ-033 cfg_req edge with cfg_div=0 in RUN: cfg_err pulses once, no cfg_ack, period stays at 10.
REQ-034 Second cfg_req edge (cfg_div=7) while in SWITCH: ignored; only the first request is acked and applied.
REQ-035 Stop asserted 2 cycles into a high phase (div 5): clk_Signal stays high 3 more cycles, then falls and stays 0 in IDLE; restart via start gives a normal first low phase of 5.
REQ-036 Reset pulled low mid-SWITCH: next cycle all outputs are 0, div_reg=5, no cfg_ack ever issued. With CYCLE_COUNT_EN, 65537 ticks yield cycle_count=1.
